memoria_dados: RTL and testbench

//   Data RAM responder for the control unit's memory interface (rd, we, endMem, dataInMem, dataOutMem).

---
 rtl/memoria_dados_if.sv | 26 ++
 rtl/memoria_dados.sv | 81 ++++++++
 tb/tb_memoria_dados.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/memoria_dados_if.sv
// Request/response bundle between the control unit and the data RAM.
// The control unit drives requests (master); the RAM answers (slave).
interface memoria_dados_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              enable;
  logic              rd;
  logic              we;
  logic [ADDR_W-1:0] endMem;
  logic [DATA_W-1:0] dataInMem;
  logic [DATA_W-1:0] dataOutMem;
  logic              dataValid;
  logic              busy;
  logic              err;

  modport master (
    output enable, rd, we, endMem, dataInMem,
    input  dataOutMem, dataValid, busy, err
  );

  modport slave (
    input  enable, rd, we, endMem, dataInMem,
    output dataOutMem, dataValid, busy, err
  );
endinterface

// File: rtl/memoria_dados.sv
// Data RAM responder: single-cycle write, registered read with 1-cycle latency.
// No backpressure; requests are dropped while busy clears the array after reset.
module memoria_dados #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  memoria_dados_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_err;
  logic              w_clr_en;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_illegal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_CLEAR;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_en    = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.enable) begin
          w_wr_en   = bus.we && !bus.rd;
          w_rd_en   = bus.rd && !bus.we;
          w_illegal = bus.rd && bus.we;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_clr_addr <= '0;
    else if (w_clr_en) r_clr_addr <= r_clr_addr + ADDR_W'(1);
  end

  // Array itself is not reset; the clear sweep zeroes it after every reset.
  always_ff @(posedge clock) begin
    if (w_clr_en)     r_mem[r_clr_addr] <= '0;
    else if (w_wr_en) r_mem[bus.endMem] <= bus.dataInMem;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en)   r_dout <= r_mem[bus.endMem];
      if (w_illegal) r_err  <= 1'b1;
    end
  end

  assign bus.dataOutMem = r_dout;
  assign bus.dataValid  = r_valid;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_memoria_dados.sv
// Scoreboard bench for memoria_dados: reads push expected data, a negedge monitor pops on dataValid.
module tb_memoria_dados;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  memoria_dados_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  memoria_dados #(.DATA_W(8), .ADDR_W(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.dataValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: dataValid=1 data=0x%0h with no read pending", bus.dataOutMem);
      end else begin
        check("read_data", 32'(bus.dataOutMem), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic en, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    bus.enable = en; bus.rd = r; bus.we = w; bus.endMem = a; bus.dataInMem = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    drive(1'b1, 1'b1, 1'b0, a, 8'h00);
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // Called at the negedge where reset_n has just risen; ends with inputs idle.
  task automatic check_clear(input string name);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_busy%0d", name, i), 32'(bus.busy), 32'd1);
      check($sformatf("%s_novalid%0d", name, i), 32'(bus.dataValid), 32'd0);
      @(negedge clock);
    end
    check($sformatf("%s_busy_done", name), 32'(bus.busy), 32'd0);
    bus.enable = 1'b0; bus.rd = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b1; bus.rd = 1'b1; bus.we = 1'b0;
    bus.endMem = 4'h0; bus.dataInMem = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_dout",  32'(bus.dataOutMem), 32'h0);
    check("rst_valid", 32'(bus.dataValid),  32'h0);
    check("rst_busy",  32'(bus.busy),       32'h1);
    check("rst_err",   32'(bus.err),        32'h0);

    // Clear with rd/enable held high, then every word reads back zero
    reset_n = 1'b1;
    check_clear("clr1");
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);

    // Read-after-write, single valid pulse, data held afterwards
    wr(4'd3, 8'hA5);
    rd(4'd3, 8'hA5);
    idle();
    idle();
    check("raw_pulse_end", 32'(bus.dataValid),  32'h0);
    check("raw_hold",      32'(bus.dataOutMem), 32'hA5);

    // Illegal rd+we: err set, no write, no valid
    drive(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C);
    idle();
    check("illegal_err",   32'(bus.err),       32'h1);
    check("illegal_valid", 32'(bus.dataValid), 32'h0);
    rd(4'd5, 8'h00);
    idle();
    idle();

    // enable=0 suppresses both write and read
    drive(1'b0, 1'b0, 1'b1, 4'd7, 8'h77);
    drive(1'b0, 1'b1, 1'b0, 4'd7, 8'h00);
    idle();
    check("disabled_valid", 32'(bus.dataValid), 32'h0);
    rd(4'd7, 8'h00);
    idle();
    idle();

    // Fill array then 16 back-to-back reads
    for (int i = 0; i < 16; i++) wr(4'(i), (i == 15) ? 8'hFF : 8'(8'h11 + i));
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), (i == 15) ? 8'hFF : 8'(8'h11 + i));
      if (i > 0) check($sformatf("b2b_valid%0d", i), 32'(bus.dataValid), 32'h1);
    end
    idle();
    check("b2b_valid_last", 32'(bus.dataValid), 32'h1);
    idle();
    check("b2b_valid_end",  32'(bus.dataValid), 32'h0);
    check("err_sticky",     32'(bus.err),       32'h1);
    wr(4'd0, 8'h99);
    idle();
    check("write_keeps_dout", 32'(bus.dataOutMem), 32'hFF);

    // Reset in the cycle a read result is being presented
    drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midread_valid", 32'(bus.dataValid),  32'h0);
    check("midread_dout",  32'(bus.dataOutMem), 32'h0);
    check("midread_busy",  32'(bus.busy),       32'h1);
    check("midread_err",   32'(bus.err),        32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset again partway through the clear; sweep must restart in full
    repeat (5) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midclr_busy",  32'(bus.busy),      32'h1);
    check("midclr_valid", 32'(bus.dataValid), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    check_clear("clr3");
    rd(4'd3, 8'h00);
    rd(4'd15, 8'h00);
    idle();
    idle();
    idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
